// File: rtl/mem_beh_pkg.sv
// Shared constants, types and helpers for the behavioural multiport memory model.
package mem_beh_pkg;

  // Deepest read pipeline supported. LATENCY must be strictly below this.
  localparam int MAX_LATENCY = 30;

  // Upper bound on the number of read ports and on the number of write ports.
  localparam int MAX_PORTS = 8;

  // Read-during-write behaviour when a read and a write hit one address in the same cycle.
  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  // Per-word error tag. The bits are carried alongside the data and only raise flags.
  // The stored data is never corrupted by them.
  typedef struct packed {
    logic derr;
    logic serr;
  } err_tag_t;

  localparam err_tag_t TAG_CLEAN = '{derr: 1'b0, serr: 1'b0};

  // Builds a tag from the per-port injection inputs.
  function automatic err_tag_t make_tag(input logic derr, input logic serr);
    err_tag_t t;
    t.derr = derr;
    t.serr = serr;
    return t;
  endfunction

endpackage

// File: rtl/mem_beh_rd_pipe.sv
// Read-return delay line for one read port: LATENCY stages of {vld, tag, data}.
// LATENCY 0 degenerates to a combinational pass-through.
module mem_beh_rd_pipe
  import mem_beh_pkg::*;
#(
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic          in_serr,
  input  logic          in_derr,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic          out_serr,
  output logic          out_derr,
  output logic [DW-1:0] out_data
);

  if (LATENCY == 0) begin : g_comb

    // Zero-latency return: valid follows the request, which the top has already masked during reset.
    always_comb begin
      out_vld  = in_vld;
      out_serr = in_vld & in_serr;
      out_derr = in_vld & in_derr;
      out_data = in_vld ? in_data : '0;
    end

  end else begin : g_pipe

    logic [LATENCY-1:0] vld_q;
    err_tag_t           tag_q  [LATENCY];
    logic [DW-1:0]      data_q [LATENCY];

    // Valid bits shift one stage per clock. The asynchronous reset flushes every in-flight read at once.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        // NOTE: sequential state uses <= so every stage samples its predecessor's pre-edge value.
        vld_q[0] <= in_vld;
        for (int s = 1; s < LATENCY; s++) begin
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    // Payload shift. NOTE: the payload registers have no reset. The valid gating on the
    // outputs keeps a stale payload from ever reaching the ports.
    always_ff @(posedge clk) begin
      tag_q[0]  <= in_vld ? make_tag(in_derr, in_serr) : TAG_CLEAN;
      data_q[0] <= in_vld ? in_data : '0;
      for (int s = 1; s < LATENCY; s++) begin
        tag_q[s]  <= tag_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end

    // Output stage: drive zeros, never stale or X values, whenever the slot is not valid.
    always_comb begin
      out_vld  = vld_q[LATENCY-1];
      out_serr = vld_q[LATENCY-1] & tag_q[LATENCY-1].serr;
      out_derr = vld_q[LATENCY-1] & tag_q[LATENCY-1].derr;
      out_data = vld_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
    end

  end

endmodule

// File: rtl/mem_beh_nrnw.sv
// Behavioural NR-read / NW-write memory model with per-bit write enables, configurable
// read latency, read-during-write selection, write-write collision counting and
// per-word error-tag injection.
module mem_beh_nrnw
  import mem_beh_pkg::*;
#(
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int WORDS    = 1024,
  parameter int LATENCY  = 2,
  parameter int RDW_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    read,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_dout,
  output logic [NR-1:0]    rd_vld,
  output logic [NR-1:0]    read_serr,
  output logic [NR-1:0]    read_derr,
  input  logic [NW-1:0]    write,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_bw,
  input  logic [NW*DW-1:0] wr_din,
  input  logic [NW-1:0]    wr_serr_inj,
  input  logic [NW-1:0]    wr_derr_inj,
  output logic             ww_coll,
  output logic [15:0]      ww_coll_cnt
);

  // Width of an index into the storage arrays.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Post-write forwarding is meaningful only when the read is registered.
  localparam bit FWD_NEW = (RDW_MODE == int'(RDW_NEW)) && (LATENCY != 0);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NR < 1 || NR > MAX_PORTS) begin : g_bad_nr
    $fatal(1, "mem_beh_nrnw: NR=%0d outside 1..%0d", NR, MAX_PORTS);
  end
  if (NW < 1 || NW > MAX_PORTS) begin : g_bad_nw
    $fatal(1, "mem_beh_nrnw: NW=%0d outside 1..%0d", NW, MAX_PORTS);
  end
  if (LATENCY < 0 || LATENCY >= MAX_LATENCY) begin : g_bad_lat
    $fatal(1, "mem_beh_nrnw: LATENCY=%0d outside 0..%0d", LATENCY, MAX_LATENCY - 1);
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $fatal(1, "mem_beh_nrnw: RDW_MODE=%0d must be 0 or 1", RDW_MODE);
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < WORDS;
  endfunction

  function automatic logic [IW-1:0] to_idx(input logic [AW-1:0] a);
    return IW'(a);
  endfunction

  // Bits with an enable set take the new data. All other bits keep the old word.
  function automatic logic [DW-1:0] merge_bits(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] bw,
                                               input logic [DW-1:0] din);
    return (~bw & old_w) | (bw & din);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem     [WORDS];
  err_tag_t      tag_mem [WORDS];

  // ---------------------------------------------------------------------------
  // Port unpacking
  // ---------------------------------------------------------------------------
  logic [AW-1:0] ra   [NR];
  logic [AW-1:0] wa   [NW];
  logic [DW-1:0] wbw  [NW];
  logic [DW-1:0] wdin [NW];

  // Split the flat port buses into per-port fields.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      ra[i] = rd_addr[i*AW +: AW];
    end
    for (int j = 0; j < NW; j++) begin
      wa[j]   = wr_addr[j*AW +: AW];
      wbw[j]  = wr_bw[j*DW +: DW];
      wdin[j] = wr_din[j*DW +: DW];
    end
  end

  // ---------------------------------------------------------------------------
  // Write merge
  // ---------------------------------------------------------------------------
  logic [NW-1:0] wr_ok;
  logic [DW-1:0] wr_word [NW];
  err_tag_t      wr_tag  [NW];

  // Accepted writes: requested, in range and not in reset. Out-of-range writes are dropped.
  always_comb begin
    for (int j = 0; j < NW; j++) begin
      wr_ok[j] = write[j] & ~rst & in_range(wa[j]);
    end
  end

  // For every accepted port, build the final word of its address by applying all ports that
  // hit the same address in ascending order. Overlapping enabled bits go to the highest index,
  // and the tag comes from the last writing port. Ports that share an address therefore commit
  // identical values.
  always_comb begin
    for (int j = 0; j < NW; j++) begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      wr_word[j] = '0;
      wr_tag[j]  = TAG_CLEAN;
      if (wr_ok[j]) begin
        wr_word[j] = mem[to_idx(wa[j])];
        for (int k = 0; k < NW; k++) begin
          if (wr_ok[k] && (wa[k] == wa[j])) begin
            wr_word[j] = merge_bits(wr_word[j], wbw[k], wdin[k]);
            wr_tag[j]  = make_tag(wr_derr_inj[k], wr_serr_inj[k]);
          end
        end
      end
    end
  end

  // Data array update. NOTE: the data array has no reset, so its contents survive rst.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NW; j++) begin
      if (wr_ok[j]) begin
        mem[to_idx(wa[j])] <= wr_word[j];
      end
    end
  end

  // Tag array update. Reset returns every word to a clean tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_mem <= '{default: TAG_CLEAN};
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_ok[j]) begin
          tag_mem[to_idx(wa[j])] <= wr_tag[j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read sampling
  // ---------------------------------------------------------------------------
  logic [NR-1:0] rd_ok;
  logic [DW-1:0] rd_data [NR];
  err_tag_t      rd_tag  [NR];

  // Sample the data and tag for each read port. An out-of-range read is still answered with
  // valid set, but its data is X. In new-data mode, same-cycle writes to the read address are
  // merged in.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_ok[i]   = read[i] & ~rst;
      rd_data[i] = '0;
      rd_tag[i]  = TAG_CLEAN;
      if (in_range(ra[i])) begin
        rd_data[i] = mem[to_idx(ra[i])];
        rd_tag[i]  = tag_mem[to_idx(ra[i])];
        if (FWD_NEW) begin
          for (int k = 0; k < NW; k++) begin
            if (wr_ok[k] && (wa[k] == ra[i])) begin
              rd_data[i] = merge_bits(rd_data[i], wbw[k], wdin[k]);
              rd_tag[i]  = make_tag(wr_derr_inj[k], wr_serr_inj[k]);
            end
          end
        end
      end else begin
        rd_data[i] = 'x;
      end
    end
  end

  // One return pipeline per read port.
  for (genvar i = 0; i < NR; i++) begin : g_rd
    mem_beh_rd_pipe #(
      .DW      (DW),
      .LATENCY (LATENCY)
    ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (rd_ok[i]),
      .in_serr  (rd_tag[i].serr),
      .in_derr  (rd_tag[i].derr),
      .in_data  (rd_data[i]),
      .out_vld  (rd_vld[i]),
      .out_serr (read_serr[i]),
      .out_derr (read_derr[i]),
      .out_data (rd_dout[i*DW +: DW])
    );
  end

  // ---------------------------------------------------------------------------
  // Write-write collision detection
  // ---------------------------------------------------------------------------
  logic coll_now;

  // A collision is two or more accepted writes to one address in the same cycle.
  always_comb begin
    coll_now = 1'b0;
    for (int j = 0; j < NW; j++) begin
      for (int k = j + 1; k < NW; k++) begin
        if (wr_ok[j] && wr_ok[k] && (wa[j] == wa[k])) begin
          coll_now = 1'b1;
        end
      end
    end
  end

  // Register the collision pulse and keep a saturating count of collision cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ww_coll     <= 1'b0;
      ww_coll_cnt <= '0;
    end else begin
      ww_coll <= coll_now;
      if (coll_now && (ww_coll_cnt != 16'hFFFF)) begin
        ww_coll_cnt <= ww_coll_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Out-of-range request reporting (simulation only)
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  // Report every out-of-range request accepted outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        if (read[i] && !in_range(ra[i])) begin
          $warning("mem_beh_nrnw: read port %0d address %0d out of range (WORDS=%0d)",
                   i, ra[i], WORDS);
        end
      end
      for (int j = 0; j < NW; j++) begin
        if (write[j] && !in_range(wa[j])) begin
          $warning("mem_beh_nrnw: write port %0d address %0d out of range, dropped (WORDS=%0d)",
                   j, wa[j], WORDS);
        end
      end
    end
  end
`endif

endmodule
